// File: rtl/store_align_unit.sv
// Store-path aligner: turns one store request into one or two byte-strobed RAM beats,
// splitting word-crossing stores and flagging illegal requests.
module store_align_unit #(
    parameter int XLEN        = 64,
    parameter int ADDR_W      = 11,
    parameter bit MISALIGN_EN = 1'b1,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB),
    localparam int WI_W  = ADDR_W - OFF_W
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_func3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_data_i,
    output logic            mem_valid_o,
    input  logic            mem_ready_i,
    output logic [WI_W-1:0] mem_addr_o,
    output logic [NB-1:0]   mem_wstrb_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic            done_o,
    output logic            err_o
);

    typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [WI_W-1:0]   mem_addr_q, mem_addr_d, b1_addr_q, b1_addr_d;
    logic [NB-1:0]     mem_wstrb_q, mem_wstrb_d, b1_strb_q, b1_strb_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d, b1_data_q, b1_data_d;
    logic              done_q, done_d;

    logic [OFF_W-1:0]  off;
    logic [WI_W-1:0]   word;
    logic [2*NB-1:0]   mask2;
    logic [2*XLEN-1:0] data2;
    logic              split, illegal;

    logic unused_addr;
    assign unused_addr = ^req_addr_i[XLEN-1:ADDR_W];

    // Two-word view of the store: low half is beat0, high half is beat1.
    always_comb begin
        off   = req_addr_i[OFF_W-1:0];
        word  = req_addr_i[ADDR_W-1:OFF_W];
        mask2 = '0;
        for (int b = 0; b < 2*NB; b++)
            mask2[b] = (b >= int'(off)) && (b < int'(off) + (1 << req_func3_i[1:0]));
        data2   = {{XLEN{1'b0}}, req_data_i} << {off, 3'b000};
        split   = |mask2[2*NB-1:NB];
        illegal = req_func3_i[2]
                | ((req_func3_i[1:0] == 2'b11) && (XLEN == 32))
                | (split && !MISALIGN_EN);
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        b1_addr_d   = b1_addr_q;
        b1_strb_d   = b1_strb_q;
        b1_data_d   = b1_data_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    if (illegal) begin
                        state_d = S_ERR;
                    end else begin
                        state_d     = S_BEAT0;
                        mem_addr_d  = word;
                        mem_wstrb_d = mask2[NB-1:0];
                        mem_wdata_d = data2[XLEN-1:0];
                        b1_addr_d   = word + WI_W'(1);
                        b1_strb_d   = mask2[2*NB-1:NB];
                        b1_data_d   = data2[2*XLEN-1:XLEN];
                    end
                end
            end
            S_BEAT0: begin
                if (mem_ready_i) begin
                    if (b1_strb_q != '0) begin
                        state_d     = S_BEAT1;
                        mem_addr_d  = b1_addr_q;
                        mem_wstrb_d = b1_strb_q;
                        mem_wdata_d = b1_data_q;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_BEAT1: begin
                if (mem_ready_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
            b1_addr_q   <= '0;
            b1_strb_q   <= '0;
            b1_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            b1_addr_q   <= b1_addr_d;
            b1_strb_q   <= b1_strb_d;
            b1_data_q   <= b1_data_d;
            done_q      <= done_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign mem_valid_o = (state_q == S_BEAT0) || (state_q == S_BEAT1);
    assign err_o       = (state_q == S_ERR);
    assign done_o      = done_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wstrb_o = mem_wstrb_q;
    assign mem_wdata_o = mem_wdata_q;

endmodule
